// File: rtl/swc1_pkg.sv
// Shared types and field positions for the swc1 8-bit compute tile.
package swc1_pkg;

  // Datapath and register-file geometry
  localparam int unsigned REG_W   = 8;
  localparam int unsigned NREGS   = 4;
  localparam int unsigned RIDX_W  = 2;
  localparam int unsigned SHAMT_W = 3;

  // ui_in field positions
  localparam int unsigned STROBE_BIT = 7;
  localparam int unsigned OP_MSB     = 6;
  localparam int unsigned OP_LSB     = 4;
  localparam int unsigned RD_MSB     = 3;
  localparam int unsigned RD_LSB     = 2;
  localparam int unsigned RS1_MSB    = 1;
  localparam int unsigned RS1_LSB    = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_LI  = 3'd7
  } op_e;

endpackage

// File: rtl/swc1_alu.sv
// Combinational 8-bit ALU for the swc1 tile.
// Ports: op_i (opcode), a_i (rs1 value), b_i (imm8) -> y_o (result, mod 256).
module swc1_alu
  import swc1_pkg::*;
(
  input  op_e              op_i,
  input  logic [REG_W-1:0] a_i,
  input  logic [REG_W-1:0] b_i,
  output logic [REG_W-1:0] y_o
);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = b_i[SHAMT_W-1:0];

  // Operation select; arithmetic wraps naturally at REG_W bits
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SLL:  y_o = a_i << shamt;
      OP_SRL:  y_o = a_i >> shamt;
      OP_LI:   y_o = b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/risc_v_wg_swc1.sv
// Tiny RISC-V-flavoured compute tile on the TinyTapeout user wrapper.
// One ALU instruction executes per rising edge of the ui_in strobe bit over
// a 4 x 8-bit register file (x0 reads zero, writes to x0 are dropped).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   ena         design select (not used)
//   ui_in       [7]=strobe [6:4]=opcode [3:2]=rd [1:0]=rs1
//   uio_in      imm8 operand
//   uo_out      last ALU result (registered)
//   uio_out     constant 0
//   uio_oe      constant 0 (all uio pins are inputs)
module risc_v_wg_swc1
  import swc1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic                            strobe_q, strobe_d;
  logic [REG_W-1:0]                result_q, result_d;
  logic [NREGS-1:1][REG_W-1:0]     regs_q, regs_d;

  logic                            exec_c;
  op_e                             op;
  logic [RIDX_W-1:0]               rd;
  logic [RIDX_W-1:0]               rs1;
  logic [REG_W-1:0]                a_c;
  logic [REG_W-1:0]                alu_y;

  logic                            unused_ena;
  assign unused_ena = ena;

  // Instruction field decode
  assign op  = op_e'(ui_in[OP_MSB:OP_LSB]);
  assign rd  = ui_in[RD_MSB:RD_LSB];
  assign rs1 = ui_in[RS1_MSB:RS1_LSB];

  // Execute only on the 0->1 transition of the strobe
  assign exec_c = ui_in[STROBE_BIT] & ~strobe_q;

  // rs1 read port; x0 is hardwired zero
  always_comb begin
    a_c = '0;
    case (rs1)
      2'd1:    a_c = regs_q[1];
      2'd2:    a_c = regs_q[2];
      2'd3:    a_c = regs_q[3];
      default: a_c = '0;
    endcase
  end

  swc1_alu u_alu (
    .op_i (op),
    .a_i  (a_c),
    .b_i  (uio_in),
    .y_o  (alu_y)
  );

  // Next-state: result always updates on execute, register write skips x0
  always_comb begin
    strobe_d = ui_in[STROBE_BIT];
    result_d = result_q;
    regs_d   = regs_q;
    if (exec_c) begin
      result_d = alu_y;
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (rd == RIDX_W'(i)) begin
          regs_d[i] = alu_y;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      result_q <= '0;
      regs_q   <= '0;
    end else begin
      strobe_q <= strobe_d;
      result_q <= result_d;
      regs_q   <= regs_d;
    end
  end

  assign uo_out  = result_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_risc_v_wg_swc1.sv
// Scoreboard bench for risc_v_wg_swc1: the driver queues hand-computed
// results as instructions are issued; a monitor pops and compares each
// time an execute edge has happened on the DUT inputs.
module tb_risc_v_wg_swc1;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SLL = 3'd5, SRL = 3'd6, LI = 3'd7;

  typedef struct {
    logic [7:0] val;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int   checks = 0;
  int   errors = 0;
  int   n_issued = 0;
  exp_t exp_q[$];

  logic m_strobe_q;
  logic exec_seen;

  risc_v_wg_swc1 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Observe the strobe pin to know when an execute edge occurred
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_strobe_q <= 1'b0;
      exec_seen  <= 1'b0;
    end else begin
      exec_seen  <= ui_in[7] && !m_strobe_q;
      m_strobe_q <= ui_in[7];
    end
  end

  // Monitor: result is visible on the negedge after the execute edge
  always @(negedge clk) begin
    if (rst_n && exec_seen) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_exec: uo_out=%02h with no queued expectation", uo_out);
      end else begin
        e = exp_q.pop_front();
        if (uo_out !== e.val) begin
          errors++;
          $display("FAIL instr%0d: uo_out got %02h expected %02h", e.id, uo_out, e.val);
        end
      end
    end
  end

  task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, want);
    end
  endtask

  // Issue one instruction, strobe held high for 'hold' cycles then one low cycle
  task automatic exec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [7:0] imm, input logic [7:0] exp, input int hold);
    @(negedge clk);
    ui_in  = {1'b1, op, rd, rs1};
    uio_in = imm;
    exp_q.push_back('{val: exp, id: n_issued});
    n_issued++;
    repeat (hold) @(negedge clk);
    ui_in[7] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check_now("reset_uo_out", uo_out, 8'h00);
    check_now("reset_uio_oe", uio_oe, 8'h00);
    check_now("reset_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    exec(ADD, 2'd0, 2'd1, 8'h00, 8'h00, 1);
    exec(ADD, 2'd0, 2'd2, 8'h00, 8'h00, 1);
    exec(ADD, 2'd0, 2'd3, 8'h00, 8'h00, 1);

    // Basic load / add / read-back
    exec(LI,  2'd1, 2'd0, 8'h5A, 8'h5A, 1);
    exec(ADD, 2'd2, 2'd1, 8'h10, 8'h6A, 1);
    exec(ADD, 2'd0, 2'd2, 8'h00, 8'h6A, 1);

    // Wrap-around, rd == rs1
    exec(LI,  2'd3, 2'd0, 8'hFF, 8'hFF, 1);
    exec(ADD, 2'd3, 2'd3, 8'h01, 8'h00, 1);
    exec(SUB, 2'd3, 2'd3, 8'h01, 8'hFF, 1);
    exec(ADD, 2'd0, 2'd3, 8'h00, 8'hFF, 1);

    // Logic and shifts on x1 = F0
    exec(LI,   2'd1, 2'd0, 8'hF0, 8'hF0, 1);
    exec(AND_, 2'd0, 2'd1, 8'h3C, 8'h30, 1);
    exec(OR_,  2'd0, 2'd1, 8'h0F, 8'hFF, 1);
    exec(XOR_, 2'd0, 2'd1, 8'hFF, 8'h0F, 1);
    exec(SLL,  2'd0, 2'd1, 8'h01, 8'hE0, 1);
    exec(SRL,  2'd0, 2'd1, 8'h04, 8'h0F, 1);
    exec(SLL,  2'd0, 2'd1, 8'h09, 8'hE0, 1);
    exec(SRL,  2'd0, 2'd1, 8'h0C, 8'h0F, 1);
    exec(SUB,  2'd0, 2'd1, 8'h01, 8'hEF, 1);
    exec(ADD,  2'd0, 2'd1, 8'h00, 8'hF0, 1);

    // x0 writes discarded
    exec(LI,  2'd0, 2'd0, 8'h77, 8'h77, 1);
    exec(ADD, 2'd1, 2'd0, 8'h00, 8'h00, 1);
    exec(ADD, 2'd0, 2'd1, 8'h00, 8'h00, 1);

    // Strobe held high executes once
    exec(LI,  2'd1, 2'd0, 8'h10, 8'h10, 1);
    exec(ADD, 2'd1, 2'd1, 8'h01, 8'h11, 5);
    exec(ADD, 2'd0, 2'd1, 8'h00, 8'h11, 1);
    check_now("hold_result_stable", uo_out, 8'h11);

    // Async reset mid-sequence, strobe already high at release
    exec(LI,  2'd1, 2'd0, 8'h42, 8'h42, 1);
    exec(LI,  2'd2, 2'd0, 8'h99, 8'h99, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_uo_out", uo_out, 8'h00);
    @(negedge clk);
    ui_in  = {1'b1, LI, 2'd2, 2'd0};
    uio_in = 8'h33;
    exp_q.push_back('{val: 8'h33, id: n_issued});
    n_issued++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ui_in[7] = 1'b0;
    @(negedge clk);
    exec(ADD, 2'd0, 2'd1, 8'h00, 8'h00, 1);
    exec(ADD, 2'd0, 2'd2, 8'h00, 8'h33, 1);
    exec(ADD, 2'd0, 2'd3, 8'h00, 8'h00, 1);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
